output_sequencer: RTL

Parametrised successor to the pass-through output stage. It accepts frames (bit pattern plus ID/duration word) through a valid/ready handshake and buffers them in a small FIFO. Each frame is presented on the outputs for exactly `duration × TICK_DIV` clock cycles, then the next frame follows with no gap. It sits between the frame generator and the physical output driver, replacing the combinational wrapper.

---
 rtl/output_seq_pkg.sv | 20 ++
 rtl/output_sequencer_frame_fifo.sv | 65 ++++++
 rtl/output_sequencer.sv | 113 +++++++++++
 3 files changed

// File: rtl/output_seq_pkg.sv
// Shared definitions for the output sequencer: FSM encodings, default
// widths and the layout of the {id, duration} word.
package output_seq_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } seqState_t;

  localparam int DEF_BITS_W = 42;
  localparam int DEF_ID_W   = 6;
  localparam int DEF_DUR_W  = 8;

  // {id, duration}: duration occupies the LSBs, id sits directly above it.
  localparam int DUR_LSB     = 0;
  localparam int DEF_DUR_MSB = DUR_LSB + DEF_DUR_W - 1;
  localparam int DEF_ID_LSB  = DEF_DUR_MSB + 1;
  localparam int DEF_ID_MSB  = DEF_ID_LSB + DEF_ID_W - 1;

endpackage

// File: rtl/output_sequencer_frame_fifo.sv
// Small frame FIFO: registered write, head frame always visible on rdData,
// occupancy count, and a clear that empties it in one edge.
module frame_fifo #(
  parameter int WIDTH = 56,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   wrEn,
  input  logic [WIDTH-1:0]       wrData,
  input  logic                   rdEn,
  output logic [WIDTH-1:0]       rdData,
  output logic [$clog2(DEPTH):0] fill
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtrReg;
  logic [AW-1:0]    rdPtrReg;
  logic [AW:0]      fillReg;
  logic             doPush;
  logic             doPop;

  // Clear wins over everything; full/empty come from the occupancy count.
  assign doPush = wrEn && !clear && (fillReg != FULL_CNT);
  assign doPop  = rdEn && !clear && (fillReg != '0);
  assign rdData = mem[rdPtrReg];
  assign fill   = fillReg;

  // Storage array, written on an accepted push.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtrReg] <= wrData;
    end
  end

  // Pointers wrap naturally; fill tracks push/pop, unchanged when both occur.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      fillReg  <= '0;
    end else if (clear) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      fillReg  <= '0;
    end else begin
      if (doPush) begin
        wrPtrReg <= wrPtrReg + 1'b1;
      end
      if (doPop) begin
        rdPtrReg <= rdPtrReg + 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   fillReg <= fillReg + 1'b1;
        2'b01:   fillReg <= fillReg - 1'b1;
        default: fillReg <= fillReg;
      endcase
    end
  end

endmodule

// File: rtl/output_sequencer.sv
// Output sequencer: buffers frames and presents each one for
// max(duration,1) * TICK_DIV cycles, back to back, with a flush abort.
module output_sequencer
  import output_seq_pkg::*;
#(
  parameter int BITS_W   = DEF_BITS_W,
  parameter int ID_W     = DEF_ID_W,
  parameter int DUR_W    = DEF_DUR_W,
  parameter int DEPTH    = 4,
  parameter int TICK_DIV = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BITS_W-1:0]      in_bits,
  input  logic [ID_W+DUR_W-1:0]  in_id_dur,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [BITS_W-1:0]      out_bits,
  output logic [ID_W+DUR_W-1:0]  out_id_dur,
  output logic                   out_active,
  output logic                   frame_done,
  output logic [$clog2(DEPTH):0] fill
);

  localparam int IDW    = ID_W + DUR_W;
  localparam int FW     = BITS_W + IDW;
  localparam int FILL_W = $clog2(DEPTH) + 1;
  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0]  ONE_TICK = DUR_W'(1);
  localparam logic [FILL_W-1:0] FULL_CNT = FILL_W'(DEPTH);

  seqState_t         stateReg;
  logic [BITS_W-1:0] bitsReg;
  logic [IDW-1:0]    idDurReg;
  logic [PRE_W-1:0]  prescaleReg;
  logic [DUR_W-1:0]  tickReg;
  logic [FW-1:0]     headFrame;
  logic [FILL_W-1:0] fifoFill;
  logic [DUR_W-1:0]  headDur;
  logic              fifoEmpty;
  logic              lastCycle;
  logic              popFrame;
  logic              pushFrame;

  assign fifoEmpty = (fifoFill == '0);
  assign headDur   = headFrame[DUR_LSB +: DUR_W];
  assign lastCycle = (stateReg == ST_PLAY) && (prescaleReg == PRE_LAST) &&
                     (tickReg == ONE_TICK);
  // Load a new frame when idle, or seamlessly on the last cycle of the current one.
  assign popFrame  = !flush && !fifoEmpty && ((stateReg == ST_IDLE) || lastCycle);
  assign pushFrame = in_valid && in_ready && !flush;

  assign in_ready   = (fifoFill != FULL_CNT);
  assign fill       = fifoFill;
  assign out_bits   = bitsReg;
  assign out_id_dur = idDurReg;
  assign out_active = (stateReg == ST_PLAY);
  assign frame_done = lastCycle;

  frame_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) uFifo (
    .clk    (clk),
    .rst    (rst),
    .clear  (flush),
    .wrEn   (pushFrame),
    .wrData ({in_bits, in_id_dur}),
    .rdEn   (popFrame),
    .rdData (headFrame),
    .fill   (fifoFill)
  );

  // Presentation FSM: load/hold/retire frames, run prescaler and tick counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg    <= ST_IDLE;
      bitsReg     <= '0;
      idDurReg    <= '0;
      prescaleReg <= '0;
      tickReg     <= '0;
    end else if (flush) begin
      stateReg    <= ST_IDLE;
      bitsReg     <= '0;
      idDurReg    <= '0;
      prescaleReg <= '0;
      tickReg     <= '0;
    end else if (popFrame) begin
      stateReg    <= ST_PLAY;
      bitsReg     <= headFrame[FW-1 -: BITS_W];
      idDurReg    <= headFrame[IDW-1:0];
      prescaleReg <= '0;
      // A zero duration is presented as one tick.
      tickReg     <= (headDur == '0) ? ONE_TICK : headDur;
    end else if (lastCycle) begin
      stateReg    <= ST_IDLE;
      bitsReg     <= '0;
      idDurReg    <= '0;
      prescaleReg <= '0;
      tickReg     <= '0;
    end else if (stateReg == ST_PLAY) begin
      if (prescaleReg == PRE_LAST) begin
        prescaleReg <= '0;
        tickReg     <= tickReg - ONE_TICK;
      end else begin
        prescaleReg <= prescaleReg + 1'b1;
      end
    end
  end

endmodule
